echo_tap_mixer: RTL and testbench
=================================

// Module: echo_tap_mixer
// PURPOSE
//  Downstream consumer of the four fixed delay lines (30/45/60/90-cycle taps).
//  - Selects one tap.
//  - Scales it by a ramped gain.
//  - Adds it to the dry input sample and drives a saturated echo output.
//  - Tap changes are declicked by a fade-out / switch / fade-in state machine,
//    so the output never steps abruptly when the tap selection changes.
// PARAMETERS
//  DW        8   sample width, signed two's complement (dry, taps, output)
//  GAIN_W    4   gain width; wet = (tap * gain) >>> GAIN_W, gain 0..2^GAIN_W-1
//  RAMP_DIV  16  clocks per one-LSB gain step during any ramp (>=1)
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       qualifies dry_in and tap0..tap3 this cycle
//  dry_in     in   DW      signed dry sample
//  tap0       in   DW      signed 30-cycle delayed sample
//  tap1       in   DW      signed 45-cycle delayed sample
//  tap2       in   DW      signed 60-cycle delayed sample
//  tap3       in   DW      signed 90-cycle delayed sample
//  tap_sel    in   2       requested tap, sampled every cycle
//  gain_tgt   in   GAIN_W  requested wet gain, sampled every cycle
//  out_valid  out  1       one-cycle strobe, out_data updated
//  out_data   out  DW      signed mixed sample, held between strobes
//  busy       out  1       high whenever FSM != IDLE
//  sat_flag   out  1       pulses with out_valid when the sum was clipped
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - out_data=0, out_valid=0, busy=0, sat_flag=0.
//   - Internal: cur_gain=0, active_sel=0, FSM=IDLE, ramp_cnt=0, pipeline valids=0.
//  Datapath, 2-stage pipeline, latency exactly 2 clocks from in_valid to out_valid:
//   - S1 registers dry_in and tap[active_sel], plus the valid bit.
//   - S2 computes prod = S1tap * {1'b0,cur_gain}, signed, DW+GAIN_W+1 bits.
//   - wet = prod >>> GAIN_W, arithmetic shift.
//   - sum = dry + wet, in DW+1 bits.
//   - out_data = sum clipped or wrapped to DW bits (see CONFIGURATION); out_valid=1.
//   - Back-to-back in_valid gives back-to-back out_valid. There is no backpressure.
//   - cur_gain and active_sel are used as they stand when S1 and S2 execute.
//  Ramp counter:
//   - Free-running clock count, cleared on every FSM state entry.
//   - When ramp_cnt==RAMP_DIV-1 it clears and one gain step fires.
//  FSM:
//   - IDLE:
//     - One step moves cur_gain by 1 toward gain_tgt; no step when equal.
//     - If tap_sel != active_sel, go to FADE_OUT next cycle.
//   - FADE_OUT:
//     - Each step decrements cur_gain by 1.
//     - When cur_gain==0, go to SWITCH; if entered with 0, leave the next cycle.
//   - SWITCH:
//     - One cycle; active_sel <= tap_sel as sampled in this cycle, then go to FADE_IN.
//   - FADE_IN:
//     - Each step moves cur_gain by 1 toward the live gain_tgt.
//     - When cur_gain==gain_tgt, go to IDLE.
//  Boundary rules:
//   - tap_sel changing during FADE_OUT or FADE_IN does not abort the fade.
//     Only SWITCH samples it.
//   - If the SWITCH sample equals active_sel, FADE_IN still runs.
//   - A leftover mismatch after FADE_IN is handled from IDLE.
//   - gain_tgt changes at any time are tracked, one LSB per step, never jumped.
//   - rst mid-fade forces IDLE with cur_gain=0 and active_sel=0.
//     rst also flushes the pipeline; no out_valid for 2 clocks after release.
//   - in_valid during SWITCH is processed normally. S1 uses the old tap that cycle.
//  Cost of a tap change: busy high for 1 + cur_gain*RAMP_DIV + 1 + gain_tgt*RAMP_DIV clocks.
// CONFIGURATION
//  ECHO_MIX_SAT_EN defined:
//   - sum is clipped to [-2^(DW-1), 2^(DW-1)-1].
//   - sat_flag=1 with out_valid when clipping occurred.
//  ECHO_MIX_SAT_EN undefined:
//   - sum is truncated to its low DW bits (two's-complement wrap).
//   - sat_flag is tied to 0.
// TESTING  (DW=8, GAIN_W=4, RAMP_DIV=4)
//  1. Gain ramp after reset:
//     - Stimulus: rst 1 clk, then gain_tgt=8, tap_sel=0.
//     - Response: cur_gain reaches 8 after 32 clks; busy stays 0 throughout.
//  2. Basic mix and latency:
//     - Stimulus: settled gain=8, in_valid with dry=10, tap0=64.
//     - Response: out_valid exactly 2 clks later with out_data=42.
//  3. Positive overflow:
//     - Stimulus: gain=15, dry=100, tap0=127 (wet=119).
//     - Response: out_data=127 and sat_flag=1 with SAT_EN; out_data=-37 and sat_flag=0 without.
//  4. Negative overflow:
//     - Stimulus: gain=15, dry=-100, tap0=-128 (wet=-120).
//     - Response: out_data=-128 with SAT_EN; out_data=36 without.
//  5. Tap switch:
//     - Stimulus: gain 8 settled, tap_sel 0->2; toggle tap_sel 2->1 mid FADE_OUT.
//     - Response: busy high for 66 clks.
//     - Response: cur_gain walks 8..0, then 0..8.
//     - Response: active_sel=1, taken at SWITCH.
//  6. Reset mid-fade:
//     - Stimulus: rst asserted during FADE_IN with continuous in_valid.
//     - Response: busy=0, out_data=0, active_sel=0 at the next clk.
//     - Response: first out_valid 2 clks after rst release.

Source files
------------

// File: rtl/echo_tap_mixer.sv
// rtl/echo_tap_mixer.sv - tap select, ramped wet gain and dry/wet mix with declicked tap switching
// Define ECHO_MIX_SAT_EN for a saturating output with sat_flag; by default the sum wraps.
module echo_tap_mixer #(
    parameter int DW       = 8,
    parameter int GAIN_W   = 4,
    parameter int RAMP_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DW-1:0]     dry_in,
    input  logic [DW-1:0]     tap0,
    input  logic [DW-1:0]     tap1,
    input  logic [DW-1:0]     tap2,
    input  logic [DW-1:0]     tap3,
    input  logic [1:0]        tap_sel,
    input  logic [GAIN_W-1:0] gain_tgt,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic              busy,
    output logic              sat_flag
);

    typedef enum logic [1:0] {IDLE, FADE_OUT, SWITCH, FADE_IN} state_t;

    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int PW = DW + GAIN_W + 1;

    state_t            state, state_nxt;
    logic [CW-1:0]     ramp_cnt;
    logic              step;
    logic [GAIN_W-1:0] cur_gain, gain_nxt, gain_toward;
    logic [1:0]        active_sel, sel_nxt;

    assign step = (ramp_cnt == CW'(RAMP_DIV - 1));
    assign busy = (state != IDLE);

    // One-LSB move toward the live target, only on a ramp step.
    always_comb begin
        gain_toward = cur_gain;
        if (step && (cur_gain < gain_tgt))
            gain_toward = cur_gain + 1'b1;
        else if (step && (cur_gain > gain_tgt))
            gain_toward = cur_gain - 1'b1;
    end

    always_comb begin
        state_nxt = state;
        gain_nxt  = cur_gain;
        sel_nxt   = active_sel;
        case (state)
            IDLE: begin
                gain_nxt = gain_toward;
                if (tap_sel != active_sel)
                    state_nxt = FADE_OUT;
            end
            FADE_OUT: begin
                if (cur_gain == '0)
                    state_nxt = SWITCH;
                else if (step)
                    gain_nxt = cur_gain - 1'b1;
            end
            SWITCH: begin
                sel_nxt   = tap_sel;
                state_nxt = FADE_IN;
            end
            default: begin
                gain_nxt = gain_toward;
                if (gain_toward == gain_tgt)
                    state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_gain   <= '0;
            active_sel <= '0;
            ramp_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            cur_gain   <= gain_nxt;
            active_sel <= sel_nxt;
            if ((state_nxt != state) || step)
                ramp_cnt <= '0;
            else
                ramp_cnt <= ramp_cnt + 1'b1;
        end
    end

    // Stage 1: capture dry and the currently active tap.
    logic                 s1_valid;
    logic signed [DW-1:0] s1_dry, s1_tap;
    logic [DW-1:0]        tap_mux;

    always_comb begin
        case (active_sel)
            2'd0:    tap_mux = tap0;
            2'd1:    tap_mux = tap1;
            2'd2:    tap_mux = tap2;
            default: tap_mux = tap3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            s1_valid <= 1'b0;
        else
            s1_valid <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            s1_dry <= dry_in;
            s1_tap <= tap_mux;
        end
    end

    // Stage 2: scale, shift back to sample range, mix.
    logic signed [PW-1:0] tap_ext, gain_ext, prod, wet, sum_full;
    logic [DW-1:0]        mixed;
    logic                 clip;

    assign tap_ext  = PW'(s1_tap);
    assign gain_ext = PW'({1'b0, cur_gain});
    assign prod     = tap_ext * gain_ext;
    assign wet      = prod >>> GAIN_W;
    assign sum_full = PW'(s1_dry) + wet;

`ifdef ECHO_MIX_SAT_EN
    localparam logic signed [PW-1:0] SUM_MAX = PW'((1 << (DW - 1)) - 1);
    localparam logic signed [PW-1:0] SUM_MIN = -SUM_MAX - 1;

    always_comb begin
        mixed = sum_full[DW-1:0];
        clip  = 1'b0;
        if (sum_full > SUM_MAX) begin
            mixed = SUM_MAX[DW-1:0];
            clip  = 1'b1;
        end else if (sum_full < SUM_MIN) begin
            mixed = SUM_MIN[DW-1:0];
            clip  = 1'b1;
        end
    end
`else
    logic unused_sum_hi;
    assign mixed         = sum_full[DW-1:0];
    assign clip          = 1'b0;
    assign unused_sum_hi = ^sum_full[PW-1:DW];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            sat_flag  <= s1_valid & clip;
            if (s1_valid)
                out_data <= mixed;
        end
    end

endmodule

// File: tb/tb_echo_tap_mixer.sv
// tb/tb_echo_tap_mixer.sv - self-checking bench for echo_tap_mixer (DW=8, GAIN_W=4, RAMP_DIV=4)
module tb_echo_tap_mixer;

    localparam int RD = 4;
    localparam int M_IDLE = 0, M_OUT = 1, M_SW = 2, M_IN = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] dry_in = '0, tap0 = '0, tap1 = '0, tap2 = '0, tap3 = '0;
    logic [1:0] tap_sel = '0;
    logic [3:0] gain_tgt = '0;
    logic       out_valid, busy, sat_flag;
    logic [7:0] out_data;

    echo_tap_mixer #(.DW(8), .GAIN_W(4), .RAMP_DIV(RD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .dry_in(dry_in),
        .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3),
        .tap_sel(tap_sel), .gain_tgt(gain_tgt),
        .out_valid(out_valid), .out_data(out_data), .busy(busy), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: mode + age-in-mode; a gain step lands every RD-th cycle of a mode.
    int m_gain, m_sel, m_mode, m_age, m_s1d, m_s1t, m_od;
    bit m_s1v, m_ov, m_sat;

    function automatic int tap_of(input int s);
        case (s)
            0:       return int'($signed(tap0));
            1:       return int'($signed(tap1));
            2:       return int'($signed(tap2));
            default: return int'($signed(tap3));
        endcase
    endfunction

    function automatic void mix(input int d, input int t, input int g, output int o, output bit s);
        int sum;
        sum = d + ((t * g) >>> 4);
        s = 1'b0;
`ifdef ECHO_MIX_SAT_EN
        if (sum > 127) begin o = 127; s = 1'b1; end
        else if (sum < -128) begin o = -128; s = 1'b1; end
        else o = sum;
`else
        o = ((sum % 256) + 256) % 256;
        if (o > 127) o = o - 256;
`endif
    endfunction

    always @(posedge clk) begin
        int g_new, mode_new, tgt, o;
        bit step, s;
        if (rst) begin
            m_gain = 0; m_sel = 0; m_mode = M_IDLE; m_age = 0;
            m_s1v = 0; m_ov = 0; m_od = 0; m_sat = 0;
        end else begin
            m_ov = m_s1v;
            m_sat = 0;
            if (m_s1v) begin
                mix(m_s1d, m_s1t, m_gain, o, s);
                m_od = o; m_sat = s;
            end
            m_s1v = in_valid;
            if (in_valid) begin
                m_s1d = int'($signed(dry_in));
                m_s1t = tap_of(m_sel);
            end
            tgt = int'(gain_tgt);
            step = ((m_age % RD) == RD - 1);
            g_new = m_gain;
            mode_new = m_mode;
            case (m_mode)
                M_IDLE: begin
                    if (step) g_new = m_gain + ((tgt > m_gain) ? 1 : (tgt < m_gain) ? -1 : 0);
                    if (int'(tap_sel) != m_sel) mode_new = M_OUT;
                end
                M_OUT: begin
                    if (m_gain == 0) mode_new = M_SW;
                    else if (step) g_new = m_gain - 1;
                end
                M_SW: begin
                    m_sel = int'(tap_sel);
                    mode_new = M_IN;
                end
                default: begin
                    if (step) g_new = m_gain + ((tgt > m_gain) ? 1 : (tgt < m_gain) ? -1 : 0);
                    if (g_new == tgt) mode_new = M_IDLE;
                end
            endcase
            m_age = (mode_new == m_mode) ? m_age + 1 : 0;
            m_gain = g_new;
            m_mode = mode_new;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", busy, (m_mode != M_IDLE));
            check("out_valid", out_valid, m_ov);
            check("out_data", $signed(out_data), m_od);
            check("sat_flag", sat_flag, m_sat);
        end
    end

    task automatic pulse(input int d, input int t);
        dry_in = 8'(d); tap0 = 8'(t); in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        check("pulse_lat1_no_valid", out_valid, 0);
        tick(1);
        check("pulse_lat2_valid", out_valid, 1);
    endtask

    initial begin
        int busy_cnt, min_out;
        bit seen;
        tick(2);
        cmp_en = 1'b1;
        check("rst_out_data", $signed(out_data), 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sat", sat_flag, 0);

        // Gain ramp: tap0=16 makes out_data equal the gain in use.
        rst = 1'b0; gain_tgt = 4'd8; tap_sel = 2'd0; in_valid = 1'b1; dry_in = '0; tap0 = 8'd16;
        tick(20);
        check("ramp_mid_gain4", $signed(out_data), 4);
        tick(20);
        check("ramp_settled_gain8", $signed(out_data), 8);
        check("ramp_busy_low", busy, 0);

        in_valid = 1'b0;
        tick(2);
        pulse(10, 64);
        check("mix_basic", $signed(out_data), 42);
        check("mix_basic_sat", sat_flag, 0);

        gain_tgt = 4'd15;
        tick(32);
        pulse(100, 127);
`ifdef ECHO_MIX_SAT_EN
        check("pos_ovf", $signed(out_data), 127);
        check("pos_ovf_sat", sat_flag, 1);
`else
        check("pos_ovf", $signed(out_data), -37);
        check("pos_ovf_sat", sat_flag, 0);
`endif
        pulse(-100, -128);
`ifdef ECHO_MIX_SAT_EN
        check("neg_ovf", $signed(out_data), -128);
        check("neg_ovf_sat", sat_flag, 1);
`else
        check("neg_ovf", $signed(out_data), 36);
        check("neg_ovf_sat", sat_flag, 0);
`endif

        // Tap switch with a toggle mid fade-out.
        gain_tgt = 4'd8;
        tick(32);
        dry_in = '0; tap0 = 8'd16; tap1 = 8'd32; tap2 = 8'd48; tap3 = 8'(-16); in_valid = 1'b1;
        tick(3);
        tap_sel = 2'd2;
        busy_cnt = 0; min_out = 999; seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (i == 10) tap_sel = 2'd1;
            if ($signed(out_data) < min_out) min_out = $signed(out_data);
            if (busy) begin
                busy_cnt++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        check("switch_busy_cycles", busy_cnt, 66);
        check("switch_gain_min", min_out, 0);
        tick(2);
        check("switch_tap1_active", $signed(out_data), 16);
        check("switch_idle_after", busy, 0);

        // Reset in the middle of a fade-in.
        tap_sel = 2'd3;
        tick(45);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1; tap_sel = 2'd0;
        tick(1);
        check("midrst_busy", busy, 0);
        check("midrst_out_data", $signed(out_data), 0);
        check("midrst_out_valid", out_valid, 0);
        rst = 1'b0;
        tick(1);
        check("release_clk1_no_valid", out_valid, 0);
        tick(1);
        check("release_clk2_valid", out_valid, 1);
        tick(40);
        check("post_rst_sel0_gain8", $signed(out_data), 8);
        check("post_rst_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
